alimentador_instrucoes: RTL
===========================

ALIMENTADOR_INSTRUCOES -- requirements
Module: alimentador_instrucoes

Interface
REQ-001 SHALL have parameter DEPTH, default 16, program memory depth in 16-bit words (power of two).
REQ-002 SHALL have parameter AW, default 4, address width, equal to log2(DEPTH).
REQ-003 SHALL have port Clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  begin program execution at address 0.
REQ-006 SHALL have port ProgLen  input  AW+1  number of valid words; sampled at Start.
REQ-007 SHALL have port WrEn  input  1  program memory write strobe.
REQ-008 SHALL have port WrAddr  input  AW  program memory write address.
REQ-009 SHALL have port WrData  input  16  program memory write data.
REQ-010 SHALL have port Done  input  1  instruction-complete from processador_multiciclo.
REQ-011 SHALL have port DIN  output  16  word presented to processor DIN.
REQ-012 SHALL have port Run  output  1  processor run enable.
REQ-013 SHALL have port Busy  output  1  high in FETCH or EXEC.
REQ-014 SHALL have port Halted  output  1  high in HALT.
REQ-015 SHALL have port Retired  output  8  instructions completed, saturating at 255.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-017 IDLE: Start=1 -> FETCH, Ptr<=0, Len<=ProgLen, Retired<=0; ProgLen=0 -> HALT directly.
REQ-018 FETCH lasts exactly one cycle (processor T0); DIN=mem[Ptr]; always -> EXEC.
REQ-019 FETCH->EXEC: if DIN[8:6]==MVI and Ptr+1<Len, Ptr<=Ptr+1 so DIN carries immediate during processor T1.
REQ-020 MVI as last word (Ptr+1==Len): Ptr unchanged, DIN=0 during EXEC, instruction still completes.
REQ-021 EXEC: DIN=mem[Ptr]; waits for Done=1; Done then -> Ptr<=Ptr+1, Retired increments (saturating).
REQ-022 EXEC with Done, next Ptr<Len -> FETCH; next Ptr==Len -> HALT (see REQ-031).
REQ-023 Done outside EXEC SHALL be ignored.
REQ-024 Run=1 in FETCH and EXEC, 0 otherwise; DIN=0 in IDLE and HALT.
REQ-025 HALT: Start=1 -> FETCH as in REQ-017; otherwise remain.
REQ-026 WrEn accepted only in IDLE or HALT; ignored when Busy; write visible to read next cycle.
REQ-027 Start while Busy SHALL be ignored.
REQ-028 Ptr arithmetic AW+1 bits; never wraps inside a program run.

Reset
REQ-029 Reset=1: state IDLE, Ptr=0, Len=0, Retired=0, Run=0, DIN=0, Busy=0, Halted=0 on next edge.
REQ-030 Reset mid-FETCH/EXEC SHALL abort immediately; memory contents SHALL be retained; Reset has priority over Start, WrEn, Done.

Configuration
REQ-031 Macro ALIMENTADOR_LOOP_EN defined: end-of-program Done -> Ptr<=0, FETCH (loop forever, Retired saturating); undefined: -> HALT, Halted=1.

Structure
REQ-032 Shared package SHALL hold opcode constants (MV=000, MVI=001, ADD=010, SUB=011) and the FSM state encoding.
REQ-033 Program storage SHALL be sub-module memoria_programa (one synchronous write port, one asynchronous read port, DEPTH x 16).

Verification
REQ-034 Load mem[0]=0x0001 (mv R0,R1), ProgLen=1, Start; Done after 2 cycles in EXEC -> DIN=0x0001 for FETCH+EXEC, Retired=1, Halted=1.
REQ-035 Load mem[0]=0x0040 (mvi R0), mem[1]=0x0005, ProgLen=2, Start -> FETCH DIN=0x0040, EXEC DIN=0x0005, after Done Halted=1, Retired=1.
REQ-036 Program mv, mvi+imm, sub (0x00C8), ProgLen=4 with processador_multiciclo attached -> Retired=3, R1=R1-R0 matches mvi value.
REQ-037 Reset asserted in EXEC of 2nd instruction -> next cycle IDLE, Run=0, DIN=0, Retired=0; restart Start re-runs program from address 0 unchanged.
REQ-038 WrEn to mem[0]=0xFFFF while Busy -> mem[0] unchanged; Done pulse in IDLE -> Retired stays 0.
REQ-039 With ALIMENTADOR_LOOP_EN, ProgLen=1, 300 Done pulses -> Ptr returns to 0 each time, Retired=255, Halted never 1.

Source files
------------

// File: rtl/alimentador_instrucoes_pkg.sv
// Shared constants for the instruction feeder: processor opcodes and feeder FSM states.
package alimentador_instrucoes_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned RET_W   = 8;
    localparam int unsigned OPC_LSB = 6;

    typedef enum logic [2:0] {
        MV  = 3'b000,
        MVI = 3'b001,
        ADD = 3'b010,
        SUB = 3'b011
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } estado_t;

    // Opcode field of an instruction word lives in bits [8:6].
    function automatic opcode_t opcode_of(input logic [DATA_W-1:0] w);
        return opcode_t'(w[OPC_LSB+2:OPC_LSB]);
    endfunction

endpackage

// File: rtl/alimentador_instrucoes_if.sv
// Control, program-load and processor-facing signals of the instruction feeder.
interface alimentador_instrucoes_if #(
    parameter int unsigned AW = 4
);
    import alimentador_instrucoes_pkg::*;

    logic                Start;
    logic [AW:0]         ProgLen;
    logic                WrEn;
    logic [AW-1:0]       WrAddr;
    logic [DATA_W-1:0]   WrData;
    logic                Done;
    logic [DATA_W-1:0]   DIN;
    logic                Run;
    logic                Busy;
    logic                Halted;
    logic [RET_W-1:0]    Retired;

    modport master (
        output Start, ProgLen, WrEn, WrAddr, WrData, Done,
        input  DIN, Run, Busy, Halted, Retired
    );

    modport slave (
        input  Start, ProgLen, WrEn, WrAddr, WrData, Done,
        output DIN, Run, Busy, Halted, Retired
    );

endinterface

// File: rtl/alimentador_instrucoes_memoria.sv
// memoria_programa: DEPTH x 16 program store, synchronous write, asynchronous read, no reset.
module memoria_programa
    import alimentador_instrucoes_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              Clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clock) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/alimentador_instrucoes.sv
// Feeds program words to processador_multiciclo one instruction at a time.
// ALIMENTADOR_LOOP_EN: restart at address 0 at end of program instead of halting.
module alimentador_instrucoes
    import alimentador_instrucoes_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    alimentador_instrucoes_if.slave bus
);

    localparam int unsigned PW = AW + 1;

    estado_t           estado;
    logic [PW-1:0]     ptr;
    logic [PW-1:0]     len;
    logic [PW-1:0]     ptr_inc;
    logic [PW-1:0]     ptr_nx;
    logic              mvi_last;
    logic              din_zero_nx;
    logic              fim;
    logic              wr_ok;
    logic [DATA_W-1:0] rd_data;

    assign ptr_inc = ptr + PW'(1);
    assign fim     = (ptr_inc >= len);
    assign wr_ok   = bus.WrEn && !Reset && (estado == IDLE || estado == HALT);

    memoria_programa #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .Clock     (Clock),
        .wr_en     (wr_ok),
        .wr_addr   (bus.WrAddr),
        .wr_data   (bus.WrData),
        .rd_addr   (ptr_nx[AW-1:0]),
        .rd_data_c (rd_data)
    );

    // Pointer for the coming cycle; DIN is registered from mem at that address.
    always_comb begin
        ptr_nx      = ptr;
        din_zero_nx = 1'b1;
        case (estado)
            IDLE, HALT: begin
                if (bus.Start) begin
                    ptr_nx      = '0;
                    din_zero_nx = (bus.ProgLen == '0);
                end
            end
            FETCH: begin
                din_zero_nx = 1'b0;
                if (opcode_of(bus.DIN) == MVI) begin
                    if (!fim) ptr_nx = ptr_inc;
                    else      din_zero_nx = 1'b1;
                end
            end
            EXEC: begin
                din_zero_nx = mvi_last;
                if (bus.Done) begin
                    ptr_nx      = ptr_inc;
                    din_zero_nx = 1'b0;
                    if (fim) begin
`ifdef ALIMENTADOR_LOOP_EN
                        ptr_nx      = '0;
`else
                        din_zero_nx = 1'b1;
`endif
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            estado      <= IDLE;
            ptr         <= '0;
            len         <= '0;
            mvi_last    <= 1'b0;
            bus.DIN     <= '0;
            bus.Run     <= 1'b0;
            bus.Busy    <= 1'b0;
            bus.Halted  <= 1'b0;
            bus.Retired <= '0;
        end else begin
            ptr     <= ptr_nx;
            bus.DIN <= din_zero_nx ? '0 : rd_data;
            case (estado)
                IDLE, HALT: begin
                    if (bus.Start) begin
                        len         <= bus.ProgLen;
                        mvi_last    <= 1'b0;
                        bus.Retired <= '0;
                        if (bus.ProgLen == '0) begin
                            estado     <= HALT;
                            bus.Run    <= 1'b0;
                            bus.Busy   <= 1'b0;
                            bus.Halted <= 1'b1;
                        end else begin
                            estado     <= FETCH;
                            bus.Run    <= 1'b1;
                            bus.Busy   <= 1'b1;
                            bus.Halted <= 1'b0;
                        end
                    end
                end
                FETCH: begin
                    estado   <= EXEC;
                    mvi_last <= (opcode_of(bus.DIN) == MVI) && fim;
                end
                EXEC: begin
                    if (bus.Done) begin
                        mvi_last <= 1'b0;
                        if (bus.Retired != {RET_W{1'b1}})
                            bus.Retired <= bus.Retired + RET_W'(1);
                        if (!fim) begin
                            estado <= FETCH;
                        end else begin
`ifdef ALIMENTADOR_LOOP_EN
                            estado <= FETCH;
`else
                            estado     <= HALT;
                            bus.Run    <= 1'b0;
                            bus.Busy   <= 1'b0;
                            bus.Halted <= 1'b1;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
